// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM state type, default widths and byte strides for the conv layer controller
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_OUT_W  = 25;

    // Byte advance per fetch strobe / per written OFM word
    localparam int IFM_STRIDE = 8;
    localparam int WGT_STRIDE = 4;
    localparam int OFM_STRIDE = 4;

endpackage

// File: rtl/ofm_merge_fifo.sv
// rtl/ofm_merge_fifo.sv - dual-push single-pop OFM merge FIFO with drop-on-full detection
module ofm_merge_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push0_v_i,
    input  logic [W-1:0] push0_data_i,
    input  logic         push1_v_i,
    input  logic [W-1:0] push1_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_nx;

    logic          a_v, b_v;
    logic [W-1:0]  a_data;
    logic          acc_a, acc_b, pop;

    // Collapse the two ports into an ordered push list and decide what fits;
    // occupancy is taken before this cycle's pop, so a pop never frees room early.
    always_comb begin
        a_v       = push0_v_i | push1_v_i;
        a_data    = push0_v_i ? push0_data_i : push1_data_i;
        b_v       = push0_v_i & push1_v_i;
        acc_a     = a_v && (count_q < DEPTH_C);
        acc_b     = b_v && ((count_q + CW'(acc_a)) < DEPTH_C);
        pop       = pop_i && (count_q != '0);
        drop_o    = (a_v & ~acc_a) | (b_v & ~acc_b);
        count_d   = count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        wr_ptr_nx = wr_ptr_q + PW'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: first accepted push lands at the write pointer, the second right after it
    always_ff @(posedge clk) begin
        if (acc_a) mem_q[wr_ptr_q]  <= a_data;
        if (acc_b) mem_q[wr_ptr_nx] <= push1_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/conv_layer_ctrl.sv
// rtl/conv_layer_ctrl.sv - conv layer sequencer, fetch address generators and OFM write-back (ReLU option: CONV_CTRL_RELU_EN)
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start,
    input  logic [1:0]        cfg_ci_i,
    input  logic [1:0]        cfg_co_i,
    input  logic [7:0]        num_tiles,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [ADDR_W-1:0] ofm_base,
    output logic              start_conv,
    output logic [1:0]        cfg_ci,
    output logic [1:0]        cfg_co,
    input  logic              ifm_read,
    input  logic              wgt_read,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic              end_conv,
    input  logic [OUT_W-1:0]  ofm_port0,
    input  logic [OUT_W-1:0]  ofm_port1,
    input  logic              ofm_port0_v,
    input  logic              ofm_port1_v,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [OUT_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              layer_done,
    output logic              ofm_ovf
);

    state_e            state_q, state_d;
    logic [7:0]        tile_cnt_q, tile_cnt_d;
    logic [7:0]        num_tiles_q;
    logic [1:0]        cfg_ci_q, cfg_co_q;
    logic [ADDR_W-1:0] ifm_ptr_q, ifm_ptr_d;
    logic [ADDR_W-1:0] wgt_ptr_q, wgt_ptr_d;
    logic [ADDR_W-1:0] ofm_ptr_q, ofm_ptr_d;
    logic              ofm_ovf_q, ofm_ovf_d;

    logic              accept_start;
    logic              fifo_empty, fifo_drop, fifo_pop;
    logic [OUT_W-1:0]  push0_data, push1_data;
    logic [OUT_W-1:0]  fifo_head;

    assign accept_start = (state_q == ST_IDLE) && layer_start;

`ifdef CONV_CTRL_RELU_EN
    assign push0_data = ofm_port0[OUT_W-1] ? '0 : ofm_port0;
    assign push1_data = ofm_port1[OUT_W-1] ? '0 : ofm_port1;
`else
    assign push0_data = ofm_port0;
    assign push1_data = ofm_port1;
`endif

    // Layer sequencing: next state, tile counting and the one-cycle pulses
    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        start_conv = 1'b0;
        layer_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (layer_start) begin
                    tile_cnt_d = '0;
                    state_d    = (num_tiles != 8'd0) ? ST_START : ST_DONE;
                end
            end
            ST_START: begin
                start_conv = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (end_conv) begin
                    tile_cnt_d = tile_cnt_q + 8'd1;
                    state_d    = (tile_cnt_q + 8'd1 == num_tiles_q) ? ST_DRAIN : ST_START;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                layer_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch/write pointers and the sticky overflow; a drop in the start cycle still counts
    always_comb begin
        ifm_ptr_d = ifm_ptr_q;
        wgt_ptr_d = wgt_ptr_q;
        ofm_ptr_d = ofm_ptr_q;
        ofm_ovf_d = ofm_ovf_q;
        if (accept_start) begin
            ifm_ptr_d = ifm_base;
            wgt_ptr_d = wgt_base;
            ofm_ptr_d = ofm_base;
            ofm_ovf_d = 1'b0;
        end else begin
            if (ifm_read) ifm_ptr_d = ifm_ptr_q + ADDR_W'(IFM_STRIDE);
            if (wgt_read) wgt_ptr_d = wgt_ptr_q + ADDR_W'(WGT_STRIDE);
            if (fifo_pop) ofm_ptr_d = ofm_ptr_q + ADDR_W'(OFM_STRIDE);
        end
        if (fifo_drop) ofm_ovf_d = 1'b1;
    end

    // State, counters, pointers and latched layer configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tile_cnt_q  <= '0;
            num_tiles_q <= '0;
            cfg_ci_q    <= '0;
            cfg_co_q    <= '0;
            ifm_ptr_q   <= '0;
            wgt_ptr_q   <= '0;
            ofm_ptr_q   <= '0;
            ofm_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            ifm_ptr_q  <= ifm_ptr_d;
            wgt_ptr_q  <= wgt_ptr_d;
            ofm_ptr_q  <= ofm_ptr_d;
            ofm_ovf_q  <= ofm_ovf_d;
            if (accept_start) begin
                num_tiles_q <= num_tiles;
                cfg_ci_q    <= cfg_ci_i;
                cfg_co_q    <= cfg_co_i;
            end
        end
    end

    ofm_merge_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push0_v_i    (ofm_port0_v),
        .push0_data_i (push0_data),
        .push1_v_i    (ofm_port1_v),
        .push1_data_i (push1_data),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .empty_o      (fifo_empty),
        .drop_o       (fifo_drop)
    );

    assign fifo_pop = wr_valid & wr_ready;
    assign wr_valid = ~fifo_empty;
    assign wr_data  = fifo_head;
    assign wr_addr  = ofm_ptr_q;
    assign ifm_addr = ifm_ptr_q;
    assign wgt_addr = wgt_ptr_q;
    assign cfg_ci   = cfg_ci_q;
    assign cfg_co   = cfg_co_q;
    assign busy     = (state_q != ST_IDLE);
    assign ofm_ovf  = ofm_ovf_q;

endmodule

// File: doc/conv_layer_ctrl.md
CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 20, byte-address width; OUT_W, 25, OFM word width; FIFO_DEPTH, 4, OFM merge FIFO entries (power of 2, >=2).
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 layer_start  in  1  one-cycle request to run a layer; sampled only in IDLE.
REQ-005 cfg_ci_i, cfg_co_i  in  2 each  channel config; cfg_ci_i and cfg_co_i latched at accepted layer_start.
REQ-006 num_tiles  in  8  tiles per layer, latched at layer_start.
REQ-007 ifm_base, wgt_base, ofm_base  in  ADDR_W each  layer base addresses, latched at layer_start.
REQ-008 start_conv  out  1  one-cycle tile start pulse to accelerator.
REQ-009 cfg_ci, cfg_co  out  2 each  latched config, held stable while busy.
REQ-010 ifm_read, wgt_read  in  1 each  accelerator fetch strobes.
REQ-011 ifm_addr, wgt_addr  out  ADDR_W each  current fetch byte addresses (combinational from registered pointers).
REQ-012 end_conv  in  1  accelerator tile-complete pulse.
REQ-013 ofm_port0, ofm_port1  in  OUT_W each; ofm_port0_v, ofm_port1_v  in  1 each  accelerator results.
REQ-014 wr_valid  out  1; wr_ready  in  1; wr_data  out  OUT_W; wr_addr  out  ADDR_W  OFM write-back port.
REQ-015 busy  out  1  state != IDLE; layer_done  out  1  one-cycle completion pulse; ofm_ovf  out  1  sticky overflow flag.

Function
REQ-016 FSM states IDLE, START, RUN, DRAIN, DONE.
REQ-017 IDLE: layer_start=1 and num_tiles!=0 -> START next cycle; layer_start=1 and num_tiles==0 -> DONE; else stay.
REQ-018 START: start_conv=1 for exactly this cycle -> RUN.
REQ-019 RUN: end_conv=1 increments tile_cnt; if new tile_cnt==num_tiles -> DRAIN, else -> START.
REQ-020 DRAIN: FIFO empty -> DONE; DONE: layer_done=1 one cycle -> IDLE.
REQ-021 layer_start outside IDLE and end_conv outside RUN are ignored.
REQ-022 ifm pointer loads ifm_base at accepted layer_start, +8 per cycle with ifm_read=1; wgt pointer loads wgt_base, +4 per cycle with wgt_read=1; pointers continue across tiles and wrap modulo 2^ADDR_W.
REQ-023 Each cycle, valid OFM ports are pushed in order port0 then port1; both valid pushes 2 entries same cycle.
REQ-024 Push that finds FIFO full (including second push of a pair when only one slot free) is dropped and sets ofm_ovf; ofm_ovf clears only at next accepted layer_start or reset.
REQ-025 wr_valid = FIFO not empty; wr_data = FIFO head; pop on wr_valid & wr_ready; simultaneous push and pop permitted, full check uses pre-pop occupancy.
REQ-026 wr_addr = ofm_base + 4*(words popped this layer), modulo 2^ADDR_W; wr_data held stable while wr_valid & !wr_ready.
REQ-027 OFM data accepted in any state (late results after DRAIN entry are still collected).

Reset
REQ-028 rst_n low: state IDLE, start_conv=0, layer_done=0, busy=0, wr_valid=0, ofm_ovf=0, tile_cnt=0, FIFO empty, all pointers and latched config/bases 0; ifm_addr=wgt_addr=wr_addr=0.
REQ-029 Reset mid-layer aborts immediately; no layer_done generated; FIFO contents discarded.

Configuration
REQ-030 Macro CONV_CTRL_RELU_EN defined: entries with signed value < 0 written to FIFO as 0 (ReLU before FIFO); undefined: raw OUT_W value stored unchanged.

Structure
REQ-031 Shared package conv_pkg: FSM state enum, default ADDR_W/OUT_W constants, byte stride constants IFM_STRIDE=8, WGT_STRIDE=4, OFM_STRIDE=4.
REQ-032 One sub-module ofm_merge_fifo: dual-push single-pop FIFO with full/overflow logic; FSM and address generators stay in top.

Verification
REQ-033 num_tiles=3, end_conv 20 cycles after each start_conv -> exactly 3 start_conv pulses, each 1 cycle after previous end_conv; layer_done once after FIFO drains.
REQ-034 ifm_base=0x100, 5 ifm_read cycles, wgt_base=0x200, 3 wgt_read cycles -> ifm_addr=0x128, wgt_addr=0x20C.
REQ-035 Both ports valid with 0x000005/0x000007, wr_ready=1, ofm_base=0x40 -> writes 5 @0x40 then 7 @0x44.
REQ-036 wr_ready=0, both ports valid 3 consecutive cycles (FIFO_DEPTH=4) -> 4 entries kept, ofm_ovf=1, later drain yields first 4 values in order.
REQ-037 ofm_port0=25'h1FFFFFF valid -> wr_data 0 with CONV_CTRL_RELU_EN, 25'h1FFFFFF without.
REQ-038 rst_n low during RUN then layer_start with num_tiles=0 -> all outputs reset values, then layer_done 1 cycle after start without start_conv.
